paddle_btn_conditioner: RTL and testbench
=========================================

PADDLE_BTN_CONDITIONER -- requirements
Module: paddle_btn_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive clk cycles a synchronized input must differ from its stable level before the stable level changes (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 12, meaning frame_tick pulses from the first move pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 2, meaning frame_tick pulses between consecutive auto-repeat pulses.
REQ-004 The block SHALL have port clk, input, 1, the system clock; reset reset, synchronous, active-high; clock clk.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port raw_left, input, 1, asynchronous bouncing left pushbutton, active-high.
REQ-007 The block SHALL have port raw_right, input, 1, asynchronous bouncing right pushbutton, active-high.
REQ-008 The block SHALL have port frame_tick, input, 1, one-clk pulse per video frame.
REQ-009 The block SHALL have port btn_left, output, 1, registered one-clk move-left pulse feeding the paddle.
REQ-010 The block SHALL have port btn_right, output, 1, registered one-clk move-right pulse feeding the paddle.
REQ-011 The block SHALL have ports stable_left and stable_right, output, 1 each, debounced button levels.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer; the synchronized value is valid 2 clk after the raw change.
REQ-013 Each channel SHALL hold a debounce counter, cleared whenever synchronized value equals stable level, incremented each clk it differs.
REQ-014 Stable level SHALL toggle, and the counter clear, on the edge where DEBOUNCE_CYCLES consecutive differing cycles have been counted; raw-to-stable latency = 2 + DEBOUNCE_CYCLES clk.
REQ-015 A mismatch shorter than DEBOUNCE_CYCLES (bounce) SHALL leave the stable level unchanged.
REQ-016 Each channel SHALL run an FSM with states IDLE, DELAY, REPEAT and a frame-tick counter wide enough for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-017 IDLE with stable=1: raise the internal move pulse for one clk, clear tick counter, go to DELAY.
REQ-018 DELAY: count frame_tick; on the tick that makes the count equal REPEAT_DELAY, raise the move pulse, clear counter, go to REPEAT.
REQ-019 REPEAT: count frame_tick; on the tick that makes the count equal REPEAT_PERIOD, raise the move pulse and clear counter; remain in REPEAT.
REQ-020 In any state, stable=0 SHALL force IDLE with no move pulse, taking priority over a same-cycle frame_tick.
REQ-021 btn_x SHALL be registered: btn_x = internal move pulse of channel x AND NOT stable level of the other channel, 1 clk after the internal pulse.
REQ-022 With both stable levels high, both outputs SHALL stay 0 while both FSMs keep running.
REQ-023 btn_left and btn_right SHALL never be high in the same cycle and never high for two consecutive cycles.

Reset
REQ-024 On reset, synchronizer flops, debounce counters, stable levels, tick counters, btn_left, btn_right SHALL be 0 and FSMs IDLE on the next edge.
REQ-025 Reset SHALL override every same-cycle event; a button held through reset SHALL re-debounce from zero after release and yield a fresh first pulse.

Structure
REQ-026 FSM state enum and default parameter constants SHALL live in the shared breakout_pkg package.
REQ-027 Synchronizer, debouncer and repeat FSM SHALL form sub-module btn_channel, instantiated twice; the top SHALL hold only arbitration and output registers.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2, frame_tick every 10 clk)
REQ-028 Bounce: raw_left toggles every 2 clk for 20 clk then stays 0 -> stable_left stays 0, btn_left never pulses.
REQ-029 Clean press: raw_left rises at clk 0 -> stable_left high at clk 6, single btn_left pulse at clk 8.
REQ-030 Hold: raw_left held 100 clk -> first pulse, then a pulse after the 3rd frame_tick, then every 2nd frame_tick; each pulse 1 clk wide.
REQ-031 Both held: raw_left and raw_right held -> no pulses; release raw_right -> btn_left resumes on its next repeat event after stable_right falls.
REQ-032 Reset mid-hold in REPEAT: outputs 0 next clk; hold continues -> stable_left rises 6 clk after reset release, fresh first pulse 2 clk later.
REQ-033 Release on tick: stable_left falls on the same clk as a qualifying frame_tick -> no pulse, FSM returns to IDLE.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game input path: repeat FSM states
// and the default timing constants for the paddle button conditioner.
package breakout_pkg;

    // Auto-repeat state of one button channel
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // 10 ms of debounce at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    // Frames from the first move pulse to the first auto-repeat pulse
    localparam int DEFAULT_REPEAT_DELAY    = 12;
    // Frames between consecutive auto-repeat pulses
    localparam int DEFAULT_REPEAT_PERIOD   = 2;

    // Larger of two integers, used to size the shared frame-tick counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton channel: 2-flop synchronizer, counting debouncer and the
// IDLE/DELAY/REPEAT auto-repeat FSM that emits one-clk move pulses.
module btn_channel
    import breakout_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic frame_tick_i,
    output logic stable_o,
    output logic move_o
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TICK_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE      = DEB_W'(1);
    localparam logic [TICK_W-1:0] TICK_ONE     = TICK_W'(1);
    localparam logic [TICK_W-1:0] DELAY_COUNT  = TICK_W'(REPEAT_DELAY);
    localparam logic [TICK_W-1:0] PERIOD_COUNT = TICK_W'(REPEAT_PERIOD);

    logic [1:0]        sync_q;
    logic              synced;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              stable_q, stable_d;
    rpt_state_e        state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TICK_W-1:0] tick_inc;
    logic              move_q, move_d;

    assign synced   = sync_q[1];
    assign stable_o = stable_q;
    assign move_o   = move_q;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw_i};
        end
    end

    // Count consecutive cycles the synchronized input disagrees with the
    // stable level; flip the level once the full debounce window is reached
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        stable_d  = stable_q;
        if (synced == stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            stable_d  = ~stable_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
    end

    // Debouncer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_q <= '0;
            stable_q  <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            stable_q  <= stable_d;
        end
    end

    // Auto-repeat next state; a released button wins over any frame tick
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        move_d     = 1'b0;
        tick_inc   = tick_cnt_q + TICK_ONE;
        case (state_q)
            IDLE: begin
                if (stable_q) begin
                    move_d     = 1'b1;
                    tick_cnt_d = '0;
                    state_d    = DELAY;
                end
            end
            DELAY: begin
                if (frame_tick_i) begin
                    if (tick_inc == DELAY_COUNT) begin
                        move_d     = 1'b1;
                        tick_cnt_d = '0;
                        state_d    = REPEAT;
                    end else begin
                        tick_cnt_d = tick_inc;
                    end
                end
            end
            REPEAT: begin
                if (frame_tick_i) begin
                    if (tick_inc == PERIOD_COUNT) begin
                        move_d     = 1'b1;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_inc;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
            end
        endcase
        if (!stable_q) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            move_d     = 1'b0;
        end
    end

    // Auto-repeat state, tick counter and registered move pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            move_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            move_q     <= move_d;
        end
    end

endmodule

// File: rtl/paddle_btn_conditioner.sv
// Paddle button conditioner: two debounced auto-repeat channels whose move
// pulses are arbitrated so only one direction is ever presented at a time.
module paddle_btn_conditioner
    import breakout_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_left,
    input  logic raw_right,
    input  logic frame_tick,
    output logic btn_left,
    output logic btn_right,
    output logic stable_left,
    output logic stable_right
);

    logic move_left, move_right;
    logic btn_left_q, btn_left_d;
    logic btn_right_q, btn_right_d;

    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_left (
        .clk         (clk),
        .reset       (reset),
        .raw_i       (raw_left),
        .frame_tick_i(frame_tick),
        .stable_o    (stable_left),
        .move_o      (move_left)
    );

    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_right (
        .clk         (clk),
        .reset       (reset),
        .raw_i       (raw_right),
        .frame_tick_i(frame_tick),
        .stable_o    (stable_right),
        .move_o      (move_right)
    );

    // A move passes only while the opposite button is released; the extra
    // terms keep the outputs exclusive and never back-to-back even when a
    // level drops in the same cycle as the other channel's pulse
    always_comb begin
        btn_left_d  = move_left & ~stable_right & ~btn_left_q & ~btn_right_q;
        btn_right_d = move_right & ~stable_left & ~btn_left_q & ~btn_right_q
                      & ~btn_left_d;
    end

    // Registered move outputs toward the paddle
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_left_q  <= 1'b0;
            btn_right_q <= 1'b0;
        end else begin
            btn_left_q  <= btn_left_d;
            btn_right_q <= btn_right_d;
        end
    end

    assign btn_left  = btn_left_q;
    assign btn_right = btn_right_q;

endmodule

// File: tb/tb_paddle_btn_conditioner.sv
// Bench for paddle_btn_conditioner with a 4-cycle debounce, 3-frame delay,
// 2-frame period and a frame tick every 10 clk.
module tb_paddle_btn_conditioner;

    typedef struct {
        int cyc;
        bit left;
    } pulse_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rawLeft = 1'b0;
    logic rawRight = 1'b0;
    logic frameTick;
    logic btnLeft, btnRight, stableLeft, stableRight;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit monitorOn = 1'b0;
    pulse_t expQ[$];

    paddle_btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (3),
        .REPEAT_PERIOD  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_left    (rawLeft),
        .raw_right   (rawRight),
        .frame_tick  (frameTick),
        .btn_left    (btnLeft),
        .btn_right   (btnRight),
        .stable_left (stableLeft),
        .stable_right(stableRight)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index: value during the cycle after the n-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // One-clk frame tick in every cycle whose index ends in 5
    assign frameTick = (cyc % 10 == 5);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic waitCycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int atCycle, input logic left,
                                 input logic right);
        waitCycle(atCycle);
        rawLeft  = left;
        rawRight = right;
    endtask

    task automatic expectPulse(input int atCycle, input bit left);
        pulse_t p;
        p.cyc  = atCycle;
        p.left = left;
        expQ.push_back(p);
    endtask

    // Monitor: every output pulse must match the next expected one
    always @(negedge clk) begin
        if (monitorOn && (btnLeft === 1'b1 || btnRight === 1'b1)) begin
            if (btnLeft === 1'b1 && btnRight === 1'b1) begin
                checks++;
                failures++;
                $display("[TB] FAIL both_outputs at cycle %0d: got both high, expected at most one", cyc);
            end else if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pulse at cycle %0d: got left=%0d right=%0d, expected none",
                         cyc, btnLeft, btnRight);
            end else begin
                pulse_t e;
                e = expQ.pop_front();
                checkOutput("pulse_cycle", cyc, e.cyc);
                checkOutput("pulse_is_left", {31'd0, btnLeft}, {31'd0, e.left});
            end
        end
    end

    initial begin
        // Reset state
        waitCycle(2);
        checkOutput("reset_btn_left", {31'd0, btnLeft}, 0);
        checkOutput("reset_btn_right", {31'd0, btnRight}, 0);
        checkOutput("reset_stable_left", {31'd0, stableLeft}, 0);
        checkOutput("reset_stable_right", {31'd0, stableRight}, 0);
        waitCycle(3);
        reset = 1'b0;
        monitorOn = 1'b1;

        // Bounce: 2-clk toggles never reach the debounce window
        for (int i = 0; i < 20; i++) begin
            applyStimulus(10 + i, ((i / 2) % 2) == 0, 1'b0);
        end
        applyStimulus(30, 1'b0, 1'b0);
        waitCycle(40);
        checkOutput("bounce_stable_left", {31'd0, stableLeft}, 0);

        // Clean press held 100 clk: first pulse, repeat after 3rd tick, then every 2nd
        expectPulse(58, 1'b1);
        expectPulse(87, 1'b1);
        expectPulse(107, 1'b1);
        expectPulse(127, 1'b1);
        expectPulse(147, 1'b1);
        applyStimulus(50, 1'b1, 1'b0);
        waitCycle(55);
        checkOutput("press_stable_before", {31'd0, stableLeft}, 0);
        waitCycle(56);
        checkOutput("press_stable_after", {31'd0, stableLeft}, 1);
        applyStimulus(150, 1'b0, 1'b0);
        waitCycle(155);
        checkOutput("release_stable_before", {31'd0, stableLeft}, 1);
        waitCycle(156);
        checkOutput("release_stable_after", {31'd0, stableLeft}, 0);

        // Both held: silent until right releases, then left resumes
        expectPulse(277, 1'b1);
        expectPulse(297, 1'b1);
        applyStimulus(200, 1'b1, 1'b1);
        waitCycle(206);
        checkOutput("both_stable_left", {31'd0, stableLeft}, 1);
        checkOutput("both_stable_right", {31'd0, stableRight}, 1);
        applyStimulus(260, 1'b1, 1'b0);
        waitCycle(266);
        checkOutput("right_release_stable", {31'd0, stableRight}, 0);
        applyStimulus(300, 1'b0, 1'b0);

        // Reset in the middle of a REPEAT hold
        expectPulse(328, 1'b1);
        expectPulse(357, 1'b1);
        expectPulse(371, 1'b1);
        expectPulse(397, 1'b1);
        applyStimulus(320, 1'b1, 1'b0);
        waitCycle(360);
        reset = 1'b1;
        waitCycle(361);
        checkOutput("midreset_btn_left", {31'd0, btnLeft}, 0);
        checkOutput("midreset_stable_left", {31'd0, stableLeft}, 0);
        waitCycle(363);
        reset = 1'b0;
        waitCycle(368);
        checkOutput("redebounce_stable_before", {31'd0, stableLeft}, 0);
        waitCycle(369);
        checkOutput("redebounce_stable_after", {31'd0, stableLeft}, 1);
        applyStimulus(400, 1'b0, 1'b0);

        // Release landing on a qualifying frame tick yields no pulse
        expectPulse(428, 1'b1);
        expectPulse(457, 1'b1);
        applyStimulus(420, 1'b1, 1'b0);
        applyStimulus(469, 1'b0, 1'b0);
        waitCycle(474);
        checkOutput("tick_release_stable_before", {31'd0, stableLeft}, 1);
        waitCycle(475);
        checkOutput("tick_release_stable_after", {31'd0, stableLeft}, 0);

        // Short right press: one right pulse
        expectPulse(518, 1'b0);
        applyStimulus(510, 1'b0, 1'b1);
        waitCycle(516);
        checkOutput("right_press_stable", {31'd0, stableRight}, 1);
        applyStimulus(520, 1'b0, 1'b0);

        waitCycle(560);
        checkOutput("missing_pulses", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
